// File: rtl/pipe_pkg.sv
// Shared pipeline types and encodings for the five-stage RV32 core.
package pipe_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0000;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b1000;
  localparam logic [3:0] ALU_AND = 4'b0011;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic [1:0] result_src;
    logic [3:0] alu_control;
  } ctrl_t;

  // Qualify single-bit controls with valid; result_src is only meaningful when writing back.
  function automatic ctrl_t sanitise_ctrl(ctrl_t c, logic valid);
    ctrl_t s;
    s            = c;
    s.regwrite   = c.regwrite & valid;
    s.memwrite   = c.memwrite & valid;
    s.branch     = c.branch & valid;
    s.jump       = c.jump & valid;
    s.alusrc     = c.alusrc & valid;
    s.result_src = s.regwrite ? c.result_src : RESULT_ALU;
    return s;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and IF/ID back-pressure; purely combinational.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic            ex_valid,
  input  logic            ex_regwrite,
  input  logic [1:0]      ex_result_src,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            ex_pc_src,
  input  logic            ex_stall,
  output logic            lu,
  output logic            stall_fd,
  output logic            flush_fd
);

  // regwrite first so a garbage result_src on stores/branches cannot leak through
  assign lu = ex_valid & ex_regwrite & (ex_result_src == RESULT_MEM) & (ex_rd != '0) &
              id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // A taken redirect makes the dependent instruction wrong-path, so it is flushed, not held.
  assign stall_fd = ex_stall | (lu & ~ex_pc_src);
  assign flush_fd = ex_pc_src & ~ex_stall;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_regwrite,
  input  logic             id_memwrite,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_alusrc,
  input  logic [1:0]       id_result_src,
  input  logic [3:0]       id_alu_control,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_pc_plus4,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             ex_pc_src,
  input  logic             ex_stall,
  input  logic             cnt_clr,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memwrite,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_alusrc,
  output logic [1:0]       ex_result_src,
  output logic [3:0]       ex_alu_control,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_pc_plus4,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic             stall_fd,
  output logic             flush_fd,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned DataW = 5 * XLEN + 3 * RA_W;

  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d, ctrl_in;
  logic [DataW-1:0] data_q, data_d, data_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu, bubble;

  hazard_detect #(
    .RA_W(RA_W)
  ) u_hazard_detect (
    .ex_valid      (valid_q),
    .ex_regwrite   (ctrl_q.regwrite),
    .ex_result_src (ctrl_q.result_src),
    .ex_rd         (ex_rd),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_pc_src     (ex_pc_src),
    .ex_stall      (ex_stall),
    .lu            (lu),
    .stall_fd      (stall_fd),
    .flush_fd      (flush_fd)
  );

  assign bubble  = ex_pc_src | lu;
  assign data_in = {id_rs1_data, id_rs2_data, id_imm, id_pc, id_pc_plus4, id_rs1, id_rs2, id_rd};

  always_comb begin
    ctrl_in = sanitise_ctrl(ctrl_t'{regwrite:    id_regwrite,
                                    memwrite:    id_memwrite,
                                    branch:      id_branch,
                                    jump:        id_jump,
                                    alusrc:      id_alusrc,
                                    result_src:  id_result_src,
                                    alu_control: id_alu_control}, id_valid);
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (!ex_stall) begin
      data_d = data_in;
      ctrl_d = ctrl_in;
      if (bubble) begin
        valid_d         = 1'b0;
        ctrl_d.regwrite = 1'b0;
        ctrl_d.memwrite = 1'b0;
        ctrl_d.branch   = 1'b0;
        ctrl_d.jump     = 1'b0;
      end else begin
        valid_d = id_valid;
      end
    end
  end

  // Clear wins over increment and is honoured even while the stage is frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!ex_stall && bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_regwrite    = ctrl_q.regwrite;
  assign ex_memwrite    = ctrl_q.memwrite;
  assign ex_branch      = ctrl_q.branch;
  assign ex_jump        = ctrl_q.jump;
  assign ex_alusrc      = ctrl_q.alusrc;
  assign ex_result_src  = ctrl_q.result_src;
  assign ex_alu_control = ctrl_q.alu_control;
  assign {ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_pc_plus4, ex_rs1, ex_rs2, ex_rd} = data_q;
  assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver queues expectations, monitor checks each cycle.
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DataW = 5 * XLEN + 3 * RA_W;

  // ctrl word: {regwrite, memwrite, branch, jump, alusrc, result_src[1:0], alu_control[3:0]}
  localparam logic [10:0] C_ADD    = 11'h402;
  localparam logic [10:0] C_LW     = 11'h452;
  localparam logic [10:0] C_SW_IN  = 11'h272;  // result_src garbage (11)
  localparam logic [10:0] C_SW_OUT = 11'h242;  // result_src sanitised to 00
  localparam logic [10:0] M_ALL    = 11'h7ff;
  localparam logic [10:0] M_BUB    = 11'h780;

  logic             clk, rst_n;
  logic             id_valid, id_regwrite, id_memwrite, id_branch, id_jump, id_alusrc;
  logic [1:0]       id_result_src;
  logic [3:0]       id_alu_control;
  logic [XLEN-1:0]  id_rs1_data, id_rs2_data, id_imm, id_pc, id_pc_plus4;
  logic [RA_W-1:0]  id_rs1, id_rs2, id_rd;
  logic             ex_pc_src, ex_stall, cnt_clr;
  logic             ex_valid, ex_regwrite, ex_memwrite, ex_branch, ex_jump, ex_alusrc;
  logic [1:0]       ex_result_src;
  logic [3:0]       ex_alu_control;
  logic [XLEN-1:0]  ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_pc_plus4;
  logic [RA_W-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic             stall_fd, flush_fd;
  logic [CNT_W-1:0] bubble_cnt;

  logic [10:0]      act_ctrl;
  logic [DataW-1:0] act_data;

  typedef struct {
    logic             v;
    logic [10:0]      c;
    logic [10:0]      m;
    logic [DataW-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic             sf;
    logic             ff;
  } exp_t;

  exp_t             sb_q[$];
  logic [DataW-1:0] last_data;
  int               checks = 0;
  int               errors = 0;

  id_ex_stage #(
    .XLEN (XLEN),
    .RA_W (RA_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_regwrite   (id_regwrite),
    .id_memwrite   (id_memwrite),
    .id_branch     (id_branch),
    .id_jump       (id_jump),
    .id_alusrc     (id_alusrc),
    .id_result_src (id_result_src),
    .id_alu_control(id_alu_control),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .ex_pc_src     (ex_pc_src),
    .ex_stall      (ex_stall),
    .cnt_clr       (cnt_clr),
    .ex_valid      (ex_valid),
    .ex_regwrite   (ex_regwrite),
    .ex_memwrite   (ex_memwrite),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump),
    .ex_alusrc     (ex_alusrc),
    .ex_result_src (ex_result_src),
    .ex_alu_control(ex_alu_control),
    .ex_rs1_data   (ex_rs1_data),
    .ex_rs2_data   (ex_rs2_data),
    .ex_imm        (ex_imm),
    .ex_pc         (ex_pc),
    .ex_pc_plus4   (ex_pc_plus4),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .stall_fd      (stall_fd),
    .flush_fd      (flush_fd),
    .bubble_cnt    (bubble_cnt)
  );

  assign act_ctrl = {ex_regwrite, ex_memwrite, ex_branch, ex_jump, ex_alusrc, ex_result_src,
                     ex_alu_control};
  assign act_data = {ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_pc_plus4, ex_rs1, ex_rs2, ex_rd};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Register-index fields are explicit; the wide data fields are tagged so holds are visible.
  task automatic issue(input logic v, input logic [10:0] c, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic [7:0] tag,
                       input logic pcs, input logic stl, input logic clr,
                       input logic e_v, input logic [10:0] e_c, input logic [10:0] e_m,
                       input logic e_hold, input logic [3:0] e_cnt, input logic e_sf,
                       input logic e_ff);
    exp_t e;
    @(negedge clk);
    id_valid    = v;
    {id_regwrite, id_memwrite, id_branch, id_jump, id_alusrc, id_result_src,
     id_alu_control} = c;
    id_rs1_data = 32'h1000_0000 | 32'(tag);
    id_rs2_data = 32'h2000_0000 | 32'(tag);
    id_imm      = 32'h3000_0000 | 32'(tag);
    id_pc       = 32'h4000_0000 | (32'(tag) << 4);
    id_pc_plus4 = (32'h4000_0000 | (32'(tag) << 4)) + 32'd4;
    id_rs1      = r1;
    id_rs2      = r2;
    id_rd       = rd;
    ex_pc_src   = pcs;
    ex_stall    = stl;
    cnt_clr     = clr;
    if (!e_hold) begin
      last_data = {id_rs1_data, id_rs2_data, id_imm, id_pc, id_pc_plus4, id_rs1, id_rs2, id_rd};
    end
    e.v   = e_v;
    e.c   = e_c;
    e.m   = e_m;
    e.d   = last_data;
    e.cnt = e_cnt;
    e.sf  = e_sf;
    e.ff  = e_ff;
    sb_q.push_back(e);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ex_valid"}, 256'(ex_valid), 256'(0));
    chk({tag, " ctrl"}, 256'(act_ctrl), 256'(0));
    chk({tag, " data"}, 256'(act_data), 256'(0));
    chk({tag, " bubble_cnt"}, 256'(bubble_cnt), 256'(0));
    chk({tag, " stall_fd"}, 256'(stall_fd), 256'(0));
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard drained", 256'(sb_q.size()), 256'(0));
    @(negedge clk);
  endtask

  // Monitor: combinational back-pressure just before the edge, registers just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("stall_fd", 256'(stall_fd), 256'(e.sf));
        chk("flush_fd", 256'(flush_fd), 256'(e.ff));
        @(posedge clk);
        #1;
        chk("ex_valid", 256'(ex_valid), 256'(e.v));
        chk("ex_ctrl", 256'(act_ctrl & e.m), 256'(e.c & e.m));
        chk("ex_data", 256'(act_data), 256'(e.d));
        chk("bubble_cnt", 256'(bubble_cnt), 256'(e.cnt));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {id_valid, id_regwrite, id_memwrite, id_branch, id_jump, id_alusrc} = '0;
    id_result_src = '0; id_alu_control = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_pc = '0; id_pc_plus4 = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    ex_pc_src = 1'b0; ex_stall = 1'b0; cnt_clr = 1'b0;
    last_data = '0;
    #3;
    chk_reset_state("initial reset");
    @(negedge clk);
    rst_n = 1'b1;

    //      v  ctrl     rs1 rs2 rd tag  pcs stl clr | e_v e_ctrl    mask  hold cnt sf ff
    issue(1, C_LW,     1,  2,  5,  1,   0, 0, 0,     1, C_LW,     M_ALL, 0,   0, 0, 0);
    issue(1, C_ADD,    3,  5,  6,  2,   0, 0, 0,     0, 11'h000,  M_BUB, 0,   1, 1, 0);
    issue(1, C_ADD,    3,  5,  6,  2,   0, 0, 0,     1, C_ADD,    M_ALL, 0,   1, 0, 0);
    issue(1, C_LW,     1,  2,  0,  3,   0, 0, 0,     1, C_LW,     M_ALL, 0,   1, 0, 0);
    issue(1, C_ADD,    0,  0,  7,  4,   0, 0, 0,     1, C_ADD,    M_ALL, 0,   1, 0, 0);
    issue(1, C_SW_IN,  2,  3,  9,  5,   0, 0, 0,     1, C_SW_OUT, M_ALL, 0,   1, 0, 0);
    issue(1, C_ADD,    9,  9, 10,  6,   0, 0, 0,     1, C_ADD,    M_ALL, 0,   1, 0, 0);
    issue(1, C_LW,     1,  2, 11,  7,   0, 0, 0,     1, C_LW,     M_ALL, 0,   1, 0, 0);
    issue(1, C_ADD,   11,  0, 12,  8,   1, 0, 0,     0, 11'h000,  M_BUB, 0,   2, 0, 1);
    issue(1, C_LW,     1,  2, 13,  9,   0, 0, 0,     1, C_LW,     M_ALL, 0,   2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      issue(1, C_ADD, 1, 13, 14, 8'(10 + i), 1, 1, 0, 1, C_LW, M_ALL, 1, 2, 1, 0);
    end
    issue(1, C_ADD,    1, 13, 14, 13,   0, 0, 1,     0, 11'h000,  M_BUB, 0,   0, 1, 0);
    issue(1, C_ADD,    1, 13, 14, 13,   0, 0, 0,     1, C_ADD,    M_ALL, 0,   0, 0, 0);
    issue(0, C_LW,     1,  2, 14, 14,   0, 0, 0,     0, 11'h000,  M_BUB, 0,   0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      issue(1, C_ADD, 1, 2, 3, 8'(20 + i), 1, 0, 0, 0, 11'h000, M_BUB, 0,
            (i > 15) ? 4'd15 : 4'(i), 0, 1);
    end
    issue(1, C_ADD,    1,  2,  3, 60,   0, 1, 1,     0, 11'h000,  M_BUB, 1,   0, 1, 0);
    issue(1, C_LW,     1,  2,  5, 40,   0, 0, 0,     1, C_LW,     M_ALL, 0,   0, 0, 0);
    issue(1, C_ADD,    5,  7,  6, 41,   0, 0, 0,     0, 11'h000,  M_BUB, 0,   1, 1, 0);
    drain();

    #2;
    rst_n   = 1'b0;
    cnt_clr = 1'b1;
    #1;
    chk_reset_state("async reset");
    last_data = '0;
    issue(1, C_ADD,    5,  6,  8, 50,   0, 0, 0,     1, C_ADD,    M_ALL, 0,   0, 0, 0);
    rst_n = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
